// File: rtl/trng_pkg.sv
// trng_pkg: shared types and defaults for the TRNG post-processing tile.
//   vn_state_t          : von Neumann pair-corrector state
//   TRNG_WIDTH_DEF      : default output word width
//   TRNG_RCT_LIMIT_DEF  : default repetition-count health-test limit
package trng_pkg;
  typedef enum logic {VN_IDLE = 1'b0, VN_HOLD = 1'b1} vn_state_t;

  localparam int TRNG_WIDTH_DEF     = 8;
  localparam int TRNG_RCT_LIMIT_DEF = 32;
endpackage

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: von Neumann pair corrector.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : low forces VN_IDLE and suppresses output
//   hold            : freezes the pair state and suppresses output
//   raw_bit/valid   : raw entropy sample
//   vn_bit/vn_valid : debiased bit, valid in the same cycle as the second
//                     sample of an unequal pair (combinational decode so the
//                     packer can register the word on that very edge)
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  input  logic raw_bit,
  input  logic raw_valid,
  output logic vn_bit,
  output logic vn_valid
);

  vn_state_t r_state;
  logic      r_first;
  logic      w_take;

  assign w_take = en && !hold && raw_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= VN_IDLE;
      r_first <= 1'b0;
    end else if (!en) begin
      r_state <= VN_IDLE;
    end else if (w_take) begin
      case (r_state)
        VN_IDLE: begin
          r_first <= raw_bit;
          r_state <= VN_HOLD;
        end
        default: r_state <= VN_IDLE;
      endcase
    end
  end

  // (1,0) -> 1 and (0,1) -> 0: the emitted bit is simply the first of the pair.
  assign vn_valid = w_take && (r_state == VN_HOLD) && (raw_bit != r_first);
  assign vn_bit   = r_first;

endmodule

// File: rtl/trng_whitener.sv
// trng_whitener: von Neumann debias, pack into WIDTH-bit words, and present
// them on a valid/ready output with a one-word pending buffer.
// Optional repetition-count health test when TRNG_HEALTH_EN is defined;
// otherwise fault is tied 0 and RCT_LIMIT is unused.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   en                   : sampling enable; low drops partial word
//   raw_bit, raw_valid   : raw entropy sample
//   out_data, out_valid  : output word and its valid
//   out_ready            : consumer handshake
//   overflow             : sticky, a raw sample was dropped under backpressure
//   fault                : sticky health-test failure
module trng_whitener
  import trng_pkg::*;
#(
  parameter int WIDTH     = TRNG_WIDTH_DEF,
  parameter int RCT_LIMIT = TRNG_RCT_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             raw_bit,
  input  logic             raw_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             fault
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_pending;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overflow;

  logic             w_vn_bit;
  logic             w_vn_valid;
  logic             w_fault;
  logic             w_out_valid;
  logic             w_hs;
  logic             w_slot_free;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;

  trng_vn_debias u_vn (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hold      (r_pending),
    .raw_bit   (raw_bit),
    .raw_valid (raw_valid),
    .vn_bit    (w_vn_bit),
    .vn_valid  (w_vn_valid)
  );

  assign w_out_valid = r_out_valid && !w_fault;
  assign w_hs        = w_out_valid && out_ready;
  assign w_slot_free = !w_out_valid || out_ready;
  assign w_word      = {r_shift[WIDTH-2:0], w_vn_bit};
  assign w_complete  = w_vn_valid && (r_cnt == CW'(WIDTH - 1));

  // Packer: the shift register is left untouched while en is low so a
  // pending full word survives; only the count is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (w_vn_valid) begin
      r_shift <= w_word;
      r_cnt   <= w_complete ? '0 : r_cnt + 1'b1;
    end
  end

  // Output register and pending slot. While pending, the debias stage is
  // held, so r_shift still holds the finished word when it transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_pending   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (en && raw_valid && r_pending)
        r_overflow <= 1'b1;

      if (w_fault) begin
        r_out_valid <= 1'b0;
      end else if (r_pending) begin
        if (w_hs) begin
          r_out_data  <= r_shift;
          r_out_valid <= 1'b1;
          r_pending   <= 1'b0;
        end
      end else if (w_complete) begin
        if (w_slot_free) begin
          r_out_data  <= w_word;
          r_out_valid <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(RCT_LIMIT + 1);

  logic [RW-1:0] r_run_cnt;
  logic          r_last_bit;
  logic          r_fault;
  logic [RW-1:0] w_run_next;
  logic          w_accept;

  // Only samples the debias stage actually consumes count toward the run.
  assign w_accept = en && raw_valid && !r_pending;

  // Zero count means "no previous sample", so the first sample starts at 1.
  // Saturates at the limit; fault is sticky anyway.
  always_comb begin
    w_run_next = RW'(1);
    if (r_run_cnt != '0 && raw_bit == r_last_bit)
      w_run_next = (r_run_cnt == RW'(RCT_LIMIT)) ? r_run_cnt : r_run_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt  <= '0;
      r_last_bit <= 1'b0;
      r_fault    <= 1'b0;
    end else if (w_accept) begin
      r_run_cnt  <= w_run_next;
      r_last_bit <= raw_bit;
      if (w_run_next == RW'(RCT_LIMIT))
        r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign out_data  = r_out_data;
  assign out_valid = w_out_valid;
  assign overflow  = r_overflow;
  assign fault     = w_fault;

endmodule

// File: tb/tb_trng_whitener.sv
module tb_trng_whitener;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       raw_bit = 1'b0;
  logic       raw_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       overflow;
  logic       fault;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  trng_whitener #(.WIDTH(8), .RCT_LIMIT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .raw_bit   (raw_bit),
    .raw_valid (raw_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .fault     (fault)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL word: got %h expected none (unexpected word)", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL word: got %h expected %h", out_data, e);
        end
      end
    end
  end

  // All tasks are entered at posedge+1 and return at posedge+1.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic raw(input logic b);
    raw_bit = b; raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic dbit(input logic b);
    raw(b); raw(!b);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) dbit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", {7'd0, out_valid}, 8'd1 - 8'd1);
    chk("rst_overflow", {7'd0, overflow}, 8'h00);
    chk("rst_fault", {7'd0, fault}, 8'h00);

    // Basic word
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    chk("basic_valid", {7'd0, out_valid}, 8'h01);
    chk("basic_data", out_data, 8'hA5);
    tick();
    chk("basic_one_cycle", {7'd0, out_valid}, 8'h00);

    // Equal pairs interleaved
    exp_q.push_back(8'hA5);
    begin
      logic [7:0] w;
      w = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
        raw(1'b0); raw(1'b0); raw(1'b1); raw(1'b1);
        dbit(w[i]);
      end
    end
    chk("eqpair_data", out_data, 8'hA5);
    tick(); tick();
    chk("eqpair_no_extra", {7'd0, out_valid}, 8'h00);

    // Backpressure
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    raw(1'b1); raw(1'b0); raw(1'b1); raw(1'b0);
    chk("bp_hold_data", out_data, 8'hA5);
    chk("bp_hold_valid", {7'd0, out_valid}, 8'h01);
    chk("bp_overflow", {7'd0, overflow}, 8'h01);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_pending_valid", {7'd0, out_valid}, 8'h01);
    chk("bp_pending_data", out_data, 8'h3C);
    out_ready = 1'b1; tick();
    chk("bp_drained", {7'd0, out_valid}, 8'h00);

    // Simultaneous completion and handshake
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 7);
    raw(1'b0);
    chk("simul_stable", out_data, 8'hA5);
    raw_bit = 1'b1; raw_valid = 1'b1; out_ready = 1'b1;
    tick();
    raw_valid = 1'b0;
    chk("simul_no_bubble", {7'd0, out_valid}, 8'h01);
    chk("simul_data", out_data, 8'h3C);
    tick();
    chk("simul_drained", {7'd0, out_valid}, 8'h00);

    // Enable drop discards partial word
    dbit(1'b1); dbit(1'b1); dbit(1'b0);
    en = 1'b0;
    raw(1'b1); raw(1'b0); raw(1'b0); raw(1'b1);
    en = 1'b1;
    exp_q.push_back(8'hF0);
    send_bits(8'hF0, 8);
    chk("endrop_data", out_data, 8'hF0);
    tick();

    // Health test
    do_reset();
    for (int i = 0; i < 31; i++) raw(1'b1);
`ifdef TRNG_HEALTH_EN
    chk("health_before", {7'd0, fault}, 8'h00);
    raw(1'b1);
    chk("health_fault", {7'd0, fault}, 8'h01);
    send_bits(8'hA5, 8);
    chk("health_blocked", {7'd0, out_valid}, 8'h00);
    tick();
    chk("health_still_blocked", {7'd0, out_valid}, 8'h00);
    do_reset();
    chk("health_rst_clears", {7'd0, fault}, 8'h00);
`else
    raw(1'b1);
    chk("health_off_fault", {7'd0, fault}, 8'h00);
    chk("health_off_valid", {7'd0, out_valid}, 8'h00);
`endif

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
